decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ARMv8 (LEGv8-subset) instruction decode stage, directly downstream of the fetch stage.
//  Holds the IF/ID pipeline register and the 32x64 register file.
//  Extracts the register fields, reads operands and sign-extends the immediate.
//  Detects load-use hazards and requests a fetch stall.
//  Consumes fetch's 32-bit instruction + its PC; drives operands/immediate to execute and stall to the PC.
// PARAMETERS
//  NUM_REGS   32  architectural registers; index 31 is XZR (reads 0, writes ignored)
//  REG_BITS    5  register index width (= clog2(NUM_REGS))
// PORTS
//  clk          in   1            single clock; all state updates on posedge
//  reset        in   1            synchronous, active-high
//  instr_in     in   `INSTR_LEN   instruction from fetch
//  pc_in        in   `WORD        PC of instr_in
//  if_valid     in   1            instr_in/pc_in valid this cycle
//  flush        in   1            taken branch: squash the IF/ID contents
//  ext_stall    in   1            downstream stall: hold IF/ID
//  ex_mem_read  in   1            instruction in EX is a load
//  ex_rd        in   REG_BITS     destination register of the instruction in EX
//  wb_en        in   1            register-file write enable
//  wb_rd        in   REG_BITS     write register index
//  wb_data      in   `WORD        write data
//  id_valid     out  1            decoded outputs valid (0 = bubble)
//  id_pc        out  `WORD        PC of the decoded instruction
//  opcode       out  11           instr[31:21]
//  rn, rd       out  REG_BITS     instr[9:5], instr[4:0]
//  reg2         out  REG_BITS     selected second source index
//  read_data1   out  `WORD        R[rn]
//  read_data2   out  `WORD        R[reg2]
//  imm_ext      out  `WORD        extended immediate
//  hazard_stall out  1            load-use stall request to fetch (freeze PC) and to IF/ID
// BEHAVIOUR
//  IF/ID register {v, instr, pc}; priority on each posedge: reset > flush > (ext_stall|hazard_stall) > load.
//   reset: v=0, instr=0, pc=0. flush: v=0; instr and pc don't-care.
//   stall: all fields hold. load: v=if_valid, instr=instr_in, pc=pc_in.
//  Latency: instruction accepted on edge N appears decoded (combinational from IF/ID) during cycle N..N+1.
//  reg2 = instr[4:0] (Rt) for CBZ/CBNZ/STUR; instr[20:16] (Rm) otherwise.
//  imm_ext by format:
//   D (LDUR/STUR): sext instr[20:12]
//   CB: sext instr[23:5]
//   B: sext instr[25:0]
//   I: zext instr[21:10]
//   R: 0
//  hazard_stall = v & ex_mem_read & (ex_rd!=31) & ((ex_rd==rn) | (uses_reg2 & ex_rd==reg2)).
//   uses_reg2 is set for R, STUR and CB formats.
//  id_valid = v & ~hazard_stall & ~flush; a hazard inserts exactly one bubble per EX load.
//  Register file: posedge write when wb_en & wb_rd!=31; reset clears all 32 entries to 0.
//   Reads are combinational; index 31 always reads 0.
//  Reset mid-operation: outputs go to id_valid=0 and hazard_stall=0 on the next edge.
//   id_pc, opcode and imm_ext go to 0 on the same edge.
//  Simultaneous flush+stall: flush wins (squash).
//   wb write to the reg being read in the same cycle: see REGFILE_BYPASS_EN.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   same-cycle read of wb_rd (wb_en=1, wb_rd!=31) returns wb_data (write-through forwarding).
//  REGFILE_BYPASS_EN undefined:
//   the read returns the pre-write value; the new value is visible from the next cycle.
// STRUCTURE
//  definitions.vh holds:
//   `WORD, `INSTR_LEN
//   opcode constants (LDUR, STUR, CBZ, CBNZ, B, ADDI, SUBI, R-type)
//   format-class encodings
//  Sub-module regfile (NUM_REGS x `WORD, 2R/1W, XZR, optional bypass); the rest stays in decode_stage.
// TESTING
//  T1 reset:
//   hold reset 2 cycles -> id_valid=0, hazard_stall=0, id_pc=0
//   afterwards read_data1/read_data2 = 0 for every index
//  T2 LDUR X2,[X1,#-8] (0xF85F8022), pc_in=0x40:
//   -> next cycle opcode=0x7C2, rn=1, rd=2, imm_ext=0xFFFF_FFFF_FFFF_FFF8, id_pc=0x40
//  T3 load-use: EX holds LDUR to X3 (ex_mem_read=1, ex_rd=3), IF/ID holds ADD X4,X3,X5
//   -> hazard_stall=1, id_valid=0, IF/ID holds; next cycle with ex_mem_read=0 -> id_valid=1
//   same case with ex_rd=31 -> hazard_stall=0
//  T4 flush:
//   flush=1 and ext_stall=1 together -> v cleared, id_valid=0 next cycle
//   ext_stall alone -> IF/ID unchanged
//  T5 writes: wb_en=1, wb_rd=7, wb_data=0xDEAD
//   -> R7 reads 0xDEAD next cycle
//   wb_rd=31 -> R31 still reads 0
//   same-cycle read of R7 -> 0xDEAD with bypass, old value without
//  T6 CBZ X9,#-4 -> reg2=9, imm_ext=-4 (64-bit)

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared widths, LEGv8 opcode constants and instruction-format classification
package decode_stage_pkg;
  localparam int WORD = 64;
  localparam int INSTR_LEN = 32;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0] OP_CBZ = 8'hB4;
  localparam logic [7:0] OP_CBNZ = 8'hB5;
  localparam logic [5:0] OP_B = 6'h05;
  localparam logic [9:0] OP_ADDI = 10'h244;
  localparam logic [9:0] OP_SUBI = 10'h344;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_D, FMT_B, FMT_CB} fmt_e;
  // Opcodes have variable length; anything unrecognised decodes as R-type
  function automatic fmt_e get_fmt(input logic [10:0] op);
    return (op == OP_LDUR || op == OP_STUR) ? FMT_D :
           (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ) ? FMT_CB :
           (op[10:5] == OP_B) ? FMT_B :
           (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI) ? FMT_I : FMT_R;
  endfunction
endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile: 2R/1W register file, top index is XZR; REGFILE_BYPASS_EN enables write-through reads
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] ra1_i,
  input  logic [REG_BITS-1:0] ra2_i,
  input  logic                we_i,
  input  logic [REG_BITS-1:0] wa_i,
  input  logic [WORD-1:0]     wd_i,
  output logic [WORD-1:0]     rd1_o,
  output logic [WORD-1:0]     rd2_o
);
  localparam logic [REG_BITS-1:0] XZR = REG_BITS'(NUM_REGS - 1);
  logic [WORD-1:0] regs_q [NUM_REGS];
  logic wr;
  assign wr = we_i && wa_i != XZR;
  always_ff @(posedge clk)
    if (reset) regs_q <= '{default: '0};
    else if (wr) regs_q[wa_i] <= wd_i;
`ifdef REGFILE_BYPASS_EN
  assign rd1_o = (ra1_i == XZR) ? '0 : (wr && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == XZR) ? '0 : (wr && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
`else
  assign rd1_o = (ra1_i == XZR) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == XZR) ? '0 : regs_q[ra2_i];
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: LEGv8 IF/ID register, field/immediate decode, operand read and load-use hazard detection
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instr_in,
  input  logic [WORD-1:0]      pc_in,
  input  logic                 if_valid,
  input  logic                 flush,
  input  logic                 ext_stall,
  input  logic                 ex_mem_read,
  input  logic [REG_BITS-1:0]  ex_rd,
  input  logic                 wb_en,
  input  logic [REG_BITS-1:0]  wb_rd,
  input  logic [WORD-1:0]      wb_data,
  output logic                 id_valid,
  output logic [WORD-1:0]      id_pc,
  output logic [10:0]          opcode,
  output logic [REG_BITS-1:0]  rn,
  output logic [REG_BITS-1:0]  rd,
  output logic [REG_BITS-1:0]  reg2,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      imm_ext,
  output logic                 hazard_stall
);
  localparam logic [REG_BITS-1:0] XZR = REG_BITS'(NUM_REGS - 1);
  logic v_q, v_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic hold, uses_reg2, is_stur;
  fmt_e fmt;
  always_comb begin
    hold = ext_stall | hazard_stall;
    v_d = flush ? 1'b0 : hold ? v_q : if_valid;
    instr_d = (flush | hold) ? instr_q : instr_in;
    pc_d = (flush | hold) ? pc_q : pc_in;
  end
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= 1'b0;
      instr_q <= '0;
      pc_q <= '0;
    end else begin
      v_q <= v_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
    end
  assign opcode = instr_q[31:21];
  assign rn = instr_q[9:5];
  assign rd = instr_q[4:0];
  assign id_pc = pc_q;
  assign fmt = get_fmt(opcode);
  assign is_stur = opcode == OP_STUR;
  assign reg2 = (fmt == FMT_CB || is_stur) ? instr_q[4:0] : instr_q[20:16];
  assign uses_reg2 = fmt == FMT_R || fmt == FMT_CB || is_stur;
  always_comb
    imm_ext = (fmt == FMT_D) ? WORD'($signed(instr_q[20:12])) :
              (fmt == FMT_CB) ? WORD'($signed(instr_q[23:5])) :
              (fmt == FMT_B) ? WORD'($signed(instr_q[25:0])) :
              (fmt == FMT_I) ? WORD'(instr_q[21:10]) : '0;
  // Stall holds IF/ID while the load in EX advances, so the bubble lasts exactly one cycle
  assign hazard_stall = v_q & ex_mem_read & (ex_rd != XZR) &
                        ((ex_rd == rn) | (uses_reg2 & (ex_rd == reg2)));
  assign id_valid = v_q & ~hazard_stall & ~flush;
  decode_stage_regfile #(.NUM_REGS(NUM_REGS), .REG_BITS(REG_BITS)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rn),
    .ra2_i (reg2),
    .we_i  (wb_en),
    .wa_i  (wb_rd),
    .wd_i  (wb_data),
    .rd1_o (read_data1),
    .rd2_o (read_data2)
  );
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed corner sequences and randomized run against a behavioural model
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset, if_valid, flush, ext_stall, ex_mem_read, wb_en;
  logic [31:0] instr_in;
  logic [63:0] pc_in, wb_data;
  logic [4:0] ex_rd, wb_rd;
  logic id_valid, hazard_stall;
  logic [63:0] id_pc, read_data1, read_data2, imm_ext;
  logic [10:0] opcode;
  logic [4:0] rn, rd, reg2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in), .if_valid(if_valid),
    .flush(flush), .ext_stall(ext_stall), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .id_valid(id_valid), .id_pc(id_pc),
    .opcode(opcode), .rn(rn), .rd(rd), .reg2(reg2), .read_data1(read_data1),
    .read_data2(read_data2), .imm_ext(imm_ext), .hazard_stall(hazard_stall)
  );
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [10:0] op;
    logic [4:0] rn, rd, reg2;
    logic [63:0] imm;
  } vec_t;
  vec_t vt[8];
  logic mv;
  logic [31:0] mi;
  logic [63:0] mpc;
  logic [63:0] mregs[32];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic string fmt_of(input logic [31:0] i);
    if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) return "D";
    if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5) return "CB";
    if (i[31:26] == 6'h05) return "B";
    if (i[31:22] == 10'h244 || i[31:22] == 10'h344) return "I";
    return "R";
  endfunction
  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    return (v >= (64'd1 << (n - 1))) ? v - (64'd1 << n) : v;
  endfunction
  function automatic logic [63:0] imm_of(input logic [31:0] i);
    string f = fmt_of(i);
    if (f == "D") return sx(64'(i[20:12]), 9);
    if (f == "CB") return sx(64'(i[23:5]), 19);
    if (f == "B") return sx(64'(i[25:0]), 26);
    if (f == "I") return 64'(i[21:10]);
    return 64'd0;
  endfunction
  function automatic logic is_stur(input logic [31:0] i);
    return i[31:21] == 11'h7C0;
  endfunction
  function automatic logic [4:0] reg2_of(input logic [31:0] i);
    return (fmt_of(i) == "CB" || is_stur(i)) ? i[4:0] : i[20:16];
  endfunction
  function automatic logic uses2(input logic [31:0] i);
    return fmt_of(i) == "R" || fmt_of(i) == "CB" || is_stur(i);
  endfunction
  function automatic logic [63:0] rdval(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return mregs[idx];
  endfunction
  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction
  function automatic logic [31:0] gen();
    logic [31:0] i = $urandom;
    i[9:5] = pick_reg();
    i[4:0] = pick_reg();
    case ($urandom_range(0, 8))
      0: i[31:21] = 11'h7C2;
      1: i[31:21] = 11'h7C0;
      2: i[31:24] = 8'hB4;
      3: i[31:24] = 8'hB5;
      4: i[31:26] = 6'h05;
      5: i[31:22] = 10'h244;
      6: i[31:22] = 10'h344;
      7: begin i[31:21] = 11'h458; i[20:16] = pick_reg(); end
      default: ;
    endcase
    return i;
  endfunction
  task automatic idle();
    {if_valid, flush, ext_stall, ex_mem_read, wb_en} = '0;
    instr_in = '0; pc_in = '0; ex_rd = '0; wb_rd = '0; wb_data = '0;
  endtask
  logic exp_haz;
  logic [63:0] same_cycle;
  initial begin
    vt[0] = '{32'hF85F8022, 64'h40, 11'h7C2, 5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFF8};
    vt[1] = '{32'hB4FFFF89, 64'h44, 11'h5A7, 5'd28, 5'd9, 5'd9, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[2] = '{32'hF8010083, 64'h48, 11'h7C0, 5'd4, 5'd3, 5'd3, 64'd16};
    vt[3] = '{32'h913FFC41, 64'h4C, 11'h489, 5'd2, 5'd1, 5'd31, 64'hFFF};
    vt[4] = '{32'h8B050064, 64'h50, 11'h458, 5'd3, 5'd4, 5'd5, 64'd0};
    vt[5] = '{32'h17FFFFFF, 64'h54, 11'h0BF, 5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[6] = '{32'hB57FFFE0, 64'h58, 11'h5AB, 5'd31, 5'd0, 5'd0, 64'h3FFFF};
    vt[7] = '{32'hD10000C5, 64'h5C, 11'h688, 5'd6, 5'd5, 5'd0, 64'd0};
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", id_valid, 0);
    chk("rst_haz", hazard_stall, 0);
    chk("rst_pc", id_pc, 0);
    reset = 1'b0;
    if_valid = 1'b1;
    for (int r = 0; r < 32; r++) begin
      instr_in = {11'h458, 5'(r), 6'd0, 5'(r), 5'd0};
      tick();
      chk($sformatf("rst_rd1_%0d", r), read_data1, 0);
      chk($sformatf("rst_rd2_%0d", r), read_data2, 0);
    end
    for (int k = 0; k < 8; k++) begin
      instr_in = vt[k].instr;
      pc_in = vt[k].pc;
      tick();
      chk($sformatf("vec%0d_valid", k), id_valid, 1);
      chk($sformatf("vec%0d_pc", k), id_pc, vt[k].pc);
      chk($sformatf("vec%0d_op", k), opcode, vt[k].op);
      chk($sformatf("vec%0d_rn", k), rn, vt[k].rn);
      chk($sformatf("vec%0d_rd", k), rd, vt[k].rd);
      chk($sformatf("vec%0d_reg2", k), reg2, vt[k].reg2);
      chk($sformatf("vec%0d_imm", k), imm_ext, vt[k].imm);
    end
    instr_in = 32'h8B050064;
    pc_in = 64'h60;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd3; instr_in = 32'hD10000C5; pc_in = 64'h64;
    #1;
    chk("lu_haz", hazard_stall, 1);
    chk("lu_bubble", id_valid, 0);
    tick();
    chk("lu_hold_op", opcode, 11'h458);
    chk("lu_hold_pc", id_pc, 64'h60);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release", id_valid, 1);
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("lu_rm", hazard_stall, 1);
    ex_rd = 5'd4;
    #1;
    chk("lu_rd_only", hazard_stall, 0);
    ex_rd = 5'd31;
    #1;
    chk("lu_xzr", hazard_stall, 0);
    ex_mem_read = 1'b0;
    tick();
    flush = 1'b1; ext_stall = 1'b1;
    #1;
    chk("fl_comb", id_valid, 0);
    tick();
    flush = 1'b0; ext_stall = 1'b0;
    chk("fl_squash", id_valid, 0);
    instr_in = 32'h8B050064; pc_in = 64'h100;
    tick();
    ext_stall = 1'b1; instr_in = 32'hD10000C5; pc_in = 64'h200;
    tick();
    chk("st_op", opcode, 11'h458);
    chk("st_pc", id_pc, 64'h100);
    chk("st_valid", id_valid, 1);
    ext_stall = 1'b0;
    instr_in = {11'h458, 5'd31, 6'd0, 5'd7, 5'd1};
    tick();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD;
`ifdef REGFILE_BYPASS_EN
    same_cycle = 64'hDEAD;
`else
    same_cycle = 64'd0;
`endif
    #1;
    chk("wb_same", read_data1, same_cycle);
    tick();
    wb_en = 1'b0;
    chk("wb_next", read_data1, 64'hDEAD);
    wb_en = 1'b1; wb_rd = 5'd31; wb_data = 64'h1234;
    #1;
    chk("wb_xzr_same", read_data2, 0);
    tick();
    wb_en = 1'b0;
    chk("wb_xzr", read_data2, 0);
    instr_in = 32'hF85F8022; pc_in = 64'h40;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    #1;
    chk("mr_haz", hazard_stall, 1);
    reset = 1'b1;
    tick();
    chk("mr_valid", id_valid, 0);
    chk("mr_haz0", hazard_stall, 0);
    chk("mr_pc", id_pc, 0);
    chk("mr_op", opcode, 0);
    chk("mr_imm", imm_ext, 0);
    reset = 1'b0; ex_mem_read = 1'b0;
    instr_in = {11'h458, 5'd0, 6'd0, 5'd7, 5'd0};
    tick();
    chk("mr_r7", read_data1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mv = 1'b0; mi = '0; mpc = '0;
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    for (int c = 0; c < 3000; c++) begin
      instr_in = gen();
      pc_in = {$urandom, $urandom};
      if_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      ext_stall = $urandom_range(0, 5) == 0;
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd = pick_reg();
      wb_en = 1'($urandom_range(0, 1));
      wb_rd = pick_reg();
      wb_data = {$urandom, $urandom};
      #1;
      exp_haz = mv && ex_mem_read && ex_rd != 5'd31 &&
                (ex_rd == mi[9:5] || (uses2(mi) && ex_rd == reg2_of(mi)));
      chk("rnd_haz", hazard_stall, exp_haz);
      chk("rnd_valid", id_valid, mv && !exp_haz && !flush);
      if (mv) begin
        chk("rnd_pc", id_pc, mpc);
        chk("rnd_op", opcode, mi[31:21]);
        chk("rnd_rn", rn, mi[9:5]);
        chk("rnd_rd", rd, mi[4:0]);
        chk("rnd_reg2", reg2, reg2_of(mi));
        chk("rnd_imm", imm_ext, imm_of(mi));
        chk("rnd_rd1", read_data1, rdval(mi[9:5]));
        chk("rnd_rd2", read_data2, rdval(reg2_of(mi)));
      end
      if (flush) mv = 1'b0;
      else if (!(ext_stall || exp_haz)) begin
        mv = if_valid; mi = instr_in; mpc = pc_in;
      end
      if (wb_en && wb_rd != 5'd31) mregs[wb_rd] = wb_data;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
